// File: rtl/ad7276_array_stream_if.sv
// ---------------------------------------------------------------------------
// ad7276_array_stream_if
// AXI-Stream beat bus carrying AD7276 samples out of the capture engine.
//   tdata  [31:16] lane index, [15:0] zero-extended sample
//   tvalid beat valid
//   tready sink ready
//   tlast  final lane of the packet
// master: capture engine side, slave: DMA/FIFO side.
// ---------------------------------------------------------------------------
interface ad7276_array_stream_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ad7276_array_stream.sv
// ---------------------------------------------------------------------------
// ad7276_array_stream
// Capture engine for an array of AD7276 ADCs sharing one CS/SCLK pair. On a
// programmable sample period it runs one 16-SCLK frame, deserialises every
// lane in parallel, snapshots the results and streams them as one packet
// (one beat per lane, tlast on the final lane).
// Ports:
//   CLK100MHz   single clock
//   ARESET      synchronous reset, active high
//   enable_i    1 = periodic conversions run
//   period_i    start-to-start sample period in clock cycles
//   cs_o        ADC chip select, active low
//   sclk_o      ADC serial clock, idles high
//   sdata_i     one data lane per ADC
//   busy_o      high from CS fall to end of the quiet time
//   overrun_o   sticky: a finished frame was dropped while a packet drained
//   m_axis      AXI-Stream master (sample beats)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | CS high, waiting for the period counter to start a frame
// S_SHIFT | CS low, 16 SCLK periods, lanes sampled on each SCLK rise
// S_QUIET | CS high for QUIET_CLKS cycles before the next frame may start
// ---------------------------------------------------------------------------
module ad7276_array_stream #(
    parameter int NUM_LANES  = 16,
    parameter int ADC_LENGTH = 12,
    parameter int LEAD_ZEROS = 2,
    parameter int SCLK_DIV   = 2,
    parameter int QUIET_CLKS = 4
) (
    input  logic                 CLK100MHz,
    input  logic                 ARESET,
    input  logic                 enable_i,
    input  logic [31:0]          period_i,
    output logic                 cs_o,
    output logic                 sclk_o,
    input  logic [NUM_LANES-1:0] sdata_i,
    output logic                 busy_o,
    output logic                 overrun_o,
    ad7276_array_stream_if.master m_axis
);

    localparam int FRAME_CLKS = 1 + 32 * SCLK_DIV + QUIET_CLKS;
    localparam logic [31:0] FRAME_MIN    = 32'(FRAME_CLKS);
    localparam logic [31:0] FRAME_RELOAD = 32'(FRAME_CLKS - 1);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [3:0]  FIRST_BIT  = 4'(LEAD_ZEROS);
    localparam logic [3:0]  LAST_BIT   = 4'(LEAD_ZEROS + ADC_LENGTH - 1);
    localparam logic [15:0] DIV_LOAD   = 16'(SCLK_DIV - 1);
    localparam logic [15:0] QUIET_LOAD = (QUIET_CLKS > 0) ? 16'(QUIET_CLKS - 1) : 16'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0]       tmr_q, tmr_d;
    logic [3:0]        rise_q, rise_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              frame_done_q, frame_done_d;
    logic              tvalid_q, tvalid_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              overrun_q, overrun_d;

    logic              start;
    logic              sclk_rise;
    logic              load_bank;

    logic [ADC_LENGTH-1:0] cap_q  [NUM_LANES];
    logic [ADC_LENGTH-1:0] bank_q [NUM_LANES];

    // Starts are only honoured from IDLE; the reload is never shorter than a
    // frame, so in steady running the counter and the FSM stay in step.
    assign start     = enable_i && (cnt_q == 32'd0) && (state_q == S_IDLE);
    assign sclk_rise = (state_q == S_SHIFT) && (tmr_q == 16'd0) && !sclk_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmr_d        = tmr_q;
        rise_d       = rise_q;
        cs_d         = cs_q;
        sclk_d       = sclk_q;
        frame_done_d = 1'b0;
        tvalid_d     = tvalid_q;
        lane_d       = lane_q;
        overrun_d    = overrun_q;
        load_bank    = 1'b0;

        if (!enable_i) begin
            cnt_d = 32'd0;
        end else if (start) begin
            cnt_d = (period_i < FRAME_MIN) ? FRAME_RELOAD : period_i - 32'd1;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    tmr_d   = DIV_LOAD;
                    rise_d  = 4'd0;
                end
            end
            S_SHIFT: begin
                if (tmr_q == 16'd0) begin
                    sclk_d = ~sclk_q;
                    tmr_d  = DIV_LOAD;
                    if (!sclk_q) begin
                        rise_d = rise_q + 4'd1;
                        if (rise_q == 4'd15) begin
                            state_d      = S_QUIET;
                            cs_d         = 1'b1;
                            tmr_d        = QUIET_LOAD;
                            frame_done_d = 1'b1;
                        end
                    end
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_QUIET: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase

        if (tvalid_q && m_axis.tready) begin
            if (lane_q == LAST_LANE) begin
                tvalid_d = 1'b0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end

        // One cycle after CS rises the last bit is in the capture registers.
        // A packet still in flight (even on its final beat) drops the frame.
        if (frame_done_q) begin
            if (tvalid_q) begin
                overrun_d = 1'b1;
            end else begin
                load_bank = 1'b1;
                tvalid_d  = 1'b1;
                lane_d    = '0;
            end
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            tmr_q        <= 16'd0;
            rise_q       <= 4'd0;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b1;
            frame_done_q <= 1'b0;
            tvalid_q     <= 1'b0;
            lane_q       <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            rise_q       <= rise_d;
            cs_q         <= cs_d;
            sclk_q       <= sclk_d;
            frame_done_q <= frame_done_d;
            tvalid_q     <= tvalid_d;
            lane_q       <= lane_d;
            overrun_q    <= overrun_d;
        end
    end

    // Only the result window is shifted in, so leading-zero and trailing bit
    // positions never reach the sample. Exactly ADC_LENGTH shifts per frame
    // fully replace the previous contents.
    always_ff @(posedge CLK100MHz) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (sclk_rise && (rise_q >= FIRST_BIT) && (rise_q <= LAST_BIT)) begin
                cap_q[k] <= ADC_LENGTH'({cap_q[k], sdata_i[k]});
            end
            if (load_bank) begin
                bank_q[k] <= cap_q[k];
            end
        end
    end

    assign cs_o      = cs_q;
    assign sclk_o    = sclk_q;
    assign busy_o    = (state_q != S_IDLE);
    assign overrun_o = overrun_q;

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tvalid_q && (lane_q == LAST_LANE);
    assign m_axis.tdata  = tvalid_q ? {16'(lane_q), 16'(bank_q[lane_q])} : 32'd0;

endmodule

// File: tb/tb_ad7276_array_stream.sv
module tb_ad7276_array_stream;

    localparam int NL = 4;
    localparam int SCLK_PERIOD = 4;   // 2 * SCLK_DIV clock cycles

    logic          clk = 1'b0;
    logic          ARESET;
    logic          enable;
    logic [31:0]   period;
    logic          cs_o, sclk_o, busy_o, overrun_o;
    logic [NL-1:0] sdata = '0;

    ad7276_array_stream_if axis();

    ad7276_array_stream #(.NUM_LANES(NL), .ADC_LENGTH(12), .LEAD_ZEROS(2),
                          .SCLK_DIV(2), .QUIET_CLKS(4)) dut (
        .CLK100MHz (clk),
        .ARESET    (ARESET),
        .enable_i  (enable),
        .period_i  (period),
        .cs_o      (cs_o),
        .sclk_o    (sclk_o),
        .sdata_i   (sdata),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .m_axis    (axis)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: 16-bit word {lead junk, result, trailing junk}, MSB first,
    // next bit presented on each SCLK fall, pointer cleared on CS fall.
    logic [11:0] val [NL];
    logic [1:0]  lead_j [NL];
    logic [1:0]  trail_j [NL];
    logic [11:0] pkt_val [NL];   // values the next checked packet must carry
    logic [3:0]  bit_idx = 4'd0;
    logic [15:0] w;

    always @(negedge sclk_o or negedge cs_o) begin
        if (!cs_o && sclk_o) begin
            bit_idx = 4'd0;
        end else if (!cs_o && !sclk_o) begin
            for (int k = 0; k < NL; k++) begin
                w = {lead_j[k], val[k], trail_j[k]};
                sdata[k] = w[15 - bit_idx];
            end
            bit_idx = bit_idx + 4'd1;
        end
    end

    // Bus / pin monitor, sampled on the falling clock edge.
    logic [32:0] got_q [$];
    int cs_falls [$];
    int rises_q [$];
    int rise_cnt = 0, last_rise = 0, sclk_per = 0, cs_rise_cyc = 0, lat = -1;
    logic cs_p = 1'b1, sclk_p = 1'b1, tv_p = 1'b0;

    always @(negedge clk) begin
        if (cs_p && !cs_o) begin
            cs_falls.push_back(cyc);
            rise_cnt = 0;
            last_rise = 0;
        end
        if (!sclk_p && sclk_o) begin
            rise_cnt++;
            if (last_rise > 0) sclk_per = cyc - last_rise;
            last_rise = cyc;
        end
        if (!cs_p && cs_o) begin
            rises_q.push_back(rise_cnt);
            cs_rise_cyc = cyc;
        end
        if (!tv_p && axis.tvalid) lat = cyc - cs_rise_cyc;
        if (axis.tvalid && axis.tready) got_q.push_back({axis.tlast, axis.tdata});
        cs_p = cs_o;
        sclk_p = sclk_o;
        tv_p = axis.tvalid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat(input int k, input logic [11:0] v);
        return {16'(k), 4'h0, v};
    endfunction

    task automatic check_packet(input string tag, input int base);
        check({tag, "_have4"}, 33'(got_q.size() >= base + NL), 33'd1);
        if (got_q.size() >= base + NL) begin
            for (int k = 0; k < NL; k++) begin
                check({tag, "_data"}, 33'(got_q[base+k][31:0]), 33'(beat(k, pkt_val[k])));
                check({tag, "_last"}, 33'(got_q[base+k][32]), 33'(k == NL - 1));
            end
        end
    endtask

    task automatic set_vals(input bit rnd, input bit junk);
        for (int k = 0; k < NL; k++) begin
            val[k]     = rnd ? 12'($urandom) : 12'h100 + 12'(k);
            lead_j[k]  = junk ? 2'($urandom) : 2'b00;
            trail_j[k] = junk ? 2'($urandom) : 2'b00;
            pkt_val[k] = val[k];
        end
    endtask

    task automatic wait_cs_low(input int max);
        int n = 0;
        while (cs_o !== 1'b0 && n < max) begin
            step(1);
            n++;
        end
        check("cs_fall_wait", 33'(cs_o), 33'd0);
    endtask

    task automatic wait_tvalid(input int max);
        int n = 0;
        while (axis.tvalid !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
        check("tvalid_wait", 33'(axis.tvalid), 33'd1);
    endtask

    int gb, fb, rb;

    initial begin
        ARESET = 1'b1;
        enable = 1'b0;
        period = 32'd200;
        axis.tready = 1'b1;
        set_vals(1'b0, 1'b0);
        step(3);
        check("rst_cs", 33'(cs_o), 33'd1);
        check("rst_sclk", 33'(sclk_o), 33'd1);
        check("rst_tvalid", 33'(axis.tvalid), 33'd0);
        check("rst_tlast", 33'(axis.tlast), 33'd0);
        check("rst_tdata", 33'(axis.tdata), 33'd0);
        check("rst_busy", 33'(busy_o), 33'd0);
        check("rst_overrun", 33'(overrun_o), 33'd0);

        // Basic periodic capture, period 200, fixed lane pattern.
        gb = got_q.size(); fb = cs_falls.size(); rb = rises_q.size();
        ARESET = 1'b0;
        enable = 1'b1;
        step(450);
        check("b_falls", 33'(cs_falls.size() - fb >= 3), 33'd1);
        if (cs_falls.size() - fb >= 3) begin
            check("b_period", 33'(cs_falls[fb+1] - cs_falls[fb]), 33'd200);
        end
        check("b_rises", 33'(rises_q[rb]), 33'd16);
        check("b_sclk_per", 33'(sclk_per), 33'(SCLK_PERIOD));
        check("b_latency", 33'(lat), 33'd1);
        check_packet("b_pkt0", gb);
        check_packet("b_pkt1", gb + NL);
        check("b_overrun", 33'(overrun_o), 33'd0);
        enable = 1'b0;
        step(150);
        check("b_idle_busy", 33'(busy_o), 33'd0);

        // Short period clamps to the frame length; random backpressure.
        set_vals(1'b1, 1'b1);
        gb = got_q.size(); fb = cs_falls.size(); rb = rises_q.size();
        period = 32'd10;
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            axis.tready = 1'($urandom_range(0, 1));
            step(1);
        end
        axis.tready = 1'b1;
        enable = 1'b0;
        step(150);
        check("c_falls", 33'(cs_falls.size() - fb >= 4), 33'd1);
        if (cs_falls.size() - fb >= 4) begin
            check("c_period0", 33'(cs_falls[fb+1] - cs_falls[fb]), 33'd69);
            check("c_period1", 33'(cs_falls[fb+3] - cs_falls[fb+2]), 33'd69);
            check("c_rises", 33'(rises_q[rb+2]), 33'd16);
        end
        check("c_sclk_per", 33'(sclk_per), 33'(SCLK_PERIOD));
        check_packet("c_pkt0", gb);
        check_packet("c_pkt1", gb + NL);

        // Backpressure: first packet held, later frames dropped, overrun set.
        ARESET = 1'b1;
        step(2);
        ARESET = 1'b0;
        set_vals(1'b1, 1'b1);
        gb = got_q.size();
        axis.tready = 1'b0;
        period = 32'd100;
        enable = 1'b1;
        step(80);
        for (int k = 0; k < NL; k++) val[k] = ~pkt_val[k];
        for (int i = 0; i < 3; i++) begin
            step(70);
            check("d_hold_tvalid", 33'(axis.tvalid), 33'd1);
            check("d_hold_tdata", 33'(axis.tdata), 33'(beat(0, pkt_val[0])));
            check("d_hold_tlast", 33'(axis.tlast), 33'd0);
        end
        check("d_overrun", 33'(overrun_o), 33'd1);
        enable = 1'b0;
        step(100);
        axis.tready = 1'b1;
        step(20);
        check("d_beats", 33'(got_q.size() - gb), 33'(NL));
        check_packet("d_pkt", gb);
        check("d_overrun_sticky", 33'(overrun_o), 33'd1);

        // enable dropped 20 cycles into a frame: that frame still completes.
        ARESET = 1'b1;
        step(1);
        check("e_overrun_clr", 33'(overrun_o), 33'd0);
        ARESET = 1'b0;
        set_vals(1'b1, 1'b1);
        gb = got_q.size(); fb = cs_falls.size();
        period = 32'd200;
        enable = 1'b1;
        wait_cs_low(10);
        step(20);
        enable = 1'b0;
        step(300);
        check("e_one_frame", 33'(cs_falls.size() - fb), 33'd1);
        check("e_beats", 33'(got_q.size() - gb), 33'(NL));
        check_packet("e_pkt", gb);

        // Reset during SHIFT, then during beat 2 of a packet.
        set_vals(1'b1, 1'b1);
        enable = 1'b1;
        wait_cs_low(10);
        step(10);
        ARESET = 1'b1;
        step(1);
        check("f1_cs", 33'(cs_o), 33'd1);
        check("f1_sclk", 33'(sclk_o), 33'd1);
        check("f1_tvalid", 33'(axis.tvalid), 33'd0);
        check("f1_busy", 33'(busy_o), 33'd0);
        ARESET = 1'b0;
        axis.tready = 1'b0;
        wait_tvalid(100);
        axis.tready = 1'b1;
        step(1);
        axis.tready = 1'b0;
        check("f2_beat2_tdata", 33'(axis.tdata), 33'(beat(1, pkt_val[1])));
        ARESET = 1'b1;
        step(1);
        check("f2_cs", 33'(cs_o), 33'd1);
        check("f2_sclk", 33'(sclk_o), 33'd1);
        check("f2_tvalid", 33'(axis.tvalid), 33'd0);
        check("f2_tlast", 33'(axis.tlast), 33'd0);
        ARESET = 1'b0;
        axis.tready = 1'b1;
        set_vals(1'b1, 1'b1);
        gb = got_q.size();
        step(100);
        check("f_beats", 33'(got_q.size() - gb), 33'(NL));
        check_packet("f_pkt", gb);
        enable = 1'b0;
        step(250);

        // All-ones / all-zeros results framed by opposite-valued junk bits.
        for (int k = 0; k < NL; k++) begin
            val[k]     = k[0] ? 12'h000 : 12'hFFF;
            lead_j[k]  = k[0] ? 2'b11 : 2'b00;
            trail_j[k] = k[0] ? 2'b11 : 2'b00;
            pkt_val[k] = val[k];
        end
        gb = got_q.size();
        enable = 1'b1;
        step(100);
        enable = 1'b0;
        check("g_sample_fff", 33'(got_q.size() > gb ? got_q[gb][15:0] : 16'hDEAD), 33'h0FFF);
        check_packet("g_pkt", gb);
        step(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
